// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates coin credit, sells one of
// N_ITEMS priced products, and returns change or refunds through a
// valid/ack handshake to the change hopper.
module vending_machine_multi #(
    parameter int unsigned                 CREDIT_W   = 8,
    parameter int unsigned                 N_ITEMS    = 4,
    parameter int unsigned                 SEL_W      = 2,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd40, 8'd30, 8'd25, 8'd15},
    parameter int unsigned                 MAX_CREDIT = 100,
    parameter int unsigned                 TIMEOUT    = 10,
    parameter int unsigned                 TO_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [4:0]          coin_value,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                vend,
    output logic [SEL_W-1:0]    vend_item,
    output logic                coin_reject,
    output logic                sel_short,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_VEND    = 2'd2;
    localparam logic [1:0] S_CHANGE  = 2'd3;

    // One extra bit so credit + coin cannot wrap before the limit compare.
    localparam int unsigned SUM_W = CREDIT_W + 1;

    logic [1:0]          state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W-1:0] change_amt_n;
    logic [SEL_W-1:0]    vend_item_n;
    logic                vend_n;
    logic                coin_reject_n;
    logic                sel_short_n;
    logic                change_valid_n;
    logic [TO_W-1:0]     to_cnt;
    logic [TO_W-1:0]     to_cnt_n;

    logic [SUM_W-1:0]    coin_sum;
    logic                coin_legal;
    logic                coin_ok;
    logic [CREDIT_W-1:0] price;
    logic                sel_found;
    logic                afford;
    logic [TO_W-1:0]     to_inc;

    // Coin legality, price lookup and affordability for the current inputs.
    always_comb begin
        coin_sum   = SUM_W'(credit) + SUM_W'(coin_value);
        coin_legal = (coin_value == 5'd5) || (coin_value == 5'd10) || (coin_value == 5'd25);
        coin_ok    = coin_legal && (coin_sum <= SUM_W'(MAX_CREDIT));
        price      = '0;
        sel_found  = 1'b0;
        for (int i = 0; i < int'(N_ITEMS); i++) begin
            if (SEL_W'(i) == sel) begin
                price     = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_found = 1'b1;
            end
        end
        afford = sel_found && (credit >= price);
        to_inc = to_cnt + TO_W'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        credit_n       = credit;
        change_amt_n   = change_amt;
        vend_item_n    = vend_item;
        vend_n         = 1'b0;
        coin_reject_n  = 1'b0;
        sel_short_n    = 1'b0;
        change_valid_n = 1'b0;
        to_cnt_n       = '0;

        case (state)
            S_IDLE: begin
                if (coin_valid) begin
                    if (coin_ok) begin
                        credit_n = CREDIT_W'(coin_sum);
                        state_n  = S_COLLECT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
                if (sel_valid) begin
                    sel_short_n = 1'b1;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    change_amt_n   = credit;
                    change_valid_n = 1'b1;
                    state_n        = S_CHANGE;
                    coin_reject_n  = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_n = coin_valid;
                    if (afford) begin
                        vend_item_n  = sel;
                        change_amt_n = credit - price;
                        vend_n       = 1'b1;
                        state_n      = S_VEND;
                    end else begin
                        sel_short_n = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_n = CREDIT_W'(coin_sum);
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end else if (to_inc >= TO_W'(TIMEOUT)) begin
                    // Idle too long: full refund.
                    change_amt_n   = credit;
                    change_valid_n = 1'b1;
                    state_n        = S_CHANGE;
                end else begin
                    to_cnt_n = to_inc;
                end
            end

            S_VEND: begin
                coin_reject_n = coin_valid;
                if (change_amt != '0) begin
                    change_valid_n = 1'b1;
                    state_n        = S_CHANGE;
                end else begin
                    credit_n = '0;
                    state_n  = S_IDLE;
                end
            end

            S_CHANGE: begin
                coin_reject_n = coin_valid;
                if (change_ack) begin
                    credit_n     = '0;
                    change_amt_n = '0;
                    state_n      = S_IDLE;
                end else begin
                    change_valid_n = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            change_amt   <= '0;
            vend_item    <= '0;
            vend         <= 1'b0;
            coin_reject  <= 1'b0;
            sel_short    <= 1'b0;
            change_valid <= 1'b0;
            to_cnt       <= '0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            change_amt   <= change_amt_n;
            vend_item    <= vend_item_n;
            vend         <= vend_n;
            coin_reject  <= coin_reject_n;
            sel_short    <= sel_short_n;
            change_valid <= change_valid_n;
            to_cnt       <= to_cnt_n;
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with hand-computed expectations.
module tb_vending_machine_multi;

    logic       clock;
    logic       reset;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       change_ack;
    logic       vend;
    logic [1:0] vend_item;
    logic       coin_reject;
    logic       sel_short;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    vending_machine_multi dut (
        .clock       (clock),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .change_ack  (change_ack),
        .vend        (vend),
        .vend_item   (vend_item),
        .coin_reject (coin_reject),
        .sel_short   (sel_short),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .credit      (credit),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check.
    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put_coin(input int unsigned v);
        coin_valid = 1'b1;
        coin_value = 5'(v);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic pick(input int unsigned s);
        sel_valid = 1'b1;
        sel       = 2'(s);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic ack();
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        coin_valid = 1'b0;
        coin_value = '0;
        sel_valid  = 1'b0;
        sel        = '0;
        cancel     = 1'b0;
        change_ack = 1'b0;
        idle(2);
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_credit", credit, 0);
        check("rst_cvalid", change_valid, 0);

        // Reset while handing out change.
        put_coin(10);
        do_cancel();
        check("pre_rst_cvalid", change_valid, 1);
        check("pre_rst_amt", change_amt, 10);
        #2 reset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_credit", credit, 0);
        check("arst_cvalid", change_valid, 0);
        check("arst_amt", change_amt, 0);
        check("arst_vend", vend, 0);
        check("arst_item", vend_item, 0);
        check("arst_rej", coin_reject, 0);
        check("arst_short", sel_short, 0);
        tick();
        reset = 1'b0;
        put_coin(5);
        check("post_rst_credit", credit, 5);
        check("post_rst_state", state, 1);
        do_cancel();
        ack();
        check("post_rst_idle", state, 0);

        // Select from IDLE is short.
        pick(1);
        check("idle_sel_short", sel_short, 1);
        check("idle_sel_state", state, 0);

        // 10+10+25, buy item 0 (15): change 30.
        put_coin(10);
        put_coin(10);
        put_coin(25);
        check("t2_credit", credit, 45);
        pick(0);
        check("t2_state_vend", state, 2);
        check("t2_vend", vend, 1);
        check("t2_item", vend_item, 0);
        check("t2_amt", change_amt, 30);
        tick();
        check("t2_vend_off", vend, 0);
        check("t2_state_chg", state, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", change_valid, 1);
            check("t2_hold_amt", change_amt, 30);
        end
        ack();
        check("t2_ack_state", state, 0);
        check("t2_ack_credit", credit, 0);
        check("t2_ack_cvalid", change_valid, 0);
        check("t2_ack_amt", change_amt, 0);

        // Short selection then enough credit for item 3 (40).
        put_coin(25);
        pick(3);
        check("t3_short", sel_short, 1);
        check("t3_credit", credit, 25);
        check("t3_state", state, 1);
        put_coin(25);
        check("t3_short_off", sel_short, 0);
        check("t3_credit50", credit, 50);
        pick(3);
        check("t3_vend", vend, 1);
        check("t3_item", vend_item, 3);
        check("t3_amt", change_amt, 10);
        tick();
        check("t3_state_chg", state, 3);
        ack();

        // Over-limit coin, illegal coin, coin losing to cancel.
        put_coin(25);
        put_coin(25);
        put_coin(25);
        put_coin(10);
        put_coin(5);
        check("t4_credit90", credit, 90);
        put_coin(25);
        check("t4_over_rej", coin_reject, 1);
        check("t4_over_credit", credit, 90);
        put_coin(7);
        check("t4_bad_rej", coin_reject, 1);
        check("t4_bad_credit", credit, 90);
        coin_valid = 1'b1;
        coin_value = 5'd5;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check("t4_cancel_rej", coin_reject, 1);
        check("t4_cancel_state", state, 3);
        check("t4_cancel_amt", change_amt, 90);
        ack();

        // Inactivity timeout after 10 idle cycles.
        put_coin(10);
        idle(9);
        check("t5_before_to", state, 1);
        tick();
        check("t5_to_state", state, 3);
        check("t5_to_amt", change_amt, 10);
        ack();
        // A coin at idle cycle 9 restarts the count.
        put_coin(10);
        idle(8);
        put_coin(5);
        idle(9);
        check("t5_restart_state", state, 1);
        check("t5_restart_credit", credit, 15);
        tick();
        check("t5_restart_to", state, 3);
        check("t5_restart_amt", change_amt, 15);
        ack();

        // Exact price: no CHANGE phase.
        put_coin(10);
        put_coin(5);
        pick(0);
        check("t6_vend", vend, 1);
        check("t6_amt", change_amt, 0);
        tick();
        check("t6_state_idle", state, 0);
        check("t6_credit", credit, 0);
        check("t6_cvalid", change_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-product Rs25 vending controller.
- Accumulates coin credit and sells one of N_ITEMS products, each with its own price.
- Returns change, refunds on cancel or on inactivity timeout, and hands change to the coin dispenser over a valid/ack handshake.
- Sits between the coin acceptor front-end, the keypad decoder and the dispenser/change-hopper drivers.

Parameters:
CREDIT_W, 8, width of the credit, price and change values, in rupees
N_ITEMS, 4, number of selectable products (at least 2)
SEL_W, 2, width of the product select; equals clog2(N_ITEMS)
PRICES, {8'd40,8'd30,8'd25,8'd15}, packed N_ITEMS*CREDIT_W price table; item i is at [i*CREDIT_W +: CREDIT_W]; every price is nonzero
MAX_CREDIT, 100, highest credit the machine may hold; must be below 2^CREDIT_W
TIMEOUT, 10, idle cycles in COLLECT before an automatic refund (at least 1)
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin_valid  in  1  one-cycle strobe: a coin is presented
coin_value  in  5  coin value in rupees; legal values are 5, 10 and 25
sel_valid  in  1  one-cycle strobe: a product is selected
sel  in  SEL_W  product index
cancel  in  1  refund request
change_ack  in  1  dispenser has taken change_amt
vend  out  1  one-cycle pulse: dispense the product
vend_item  out  SEL_W  product index, valid while vend=1
coin_reject  out  1  one-cycle pulse: last coin was returned
sel_short  out  1  one-cycle pulse: credit was insufficient for the selection
change_valid  out  1  change_amt is valid
change_amt  out  CREDIT_W  change or refund amount in rupees
credit  out  CREDIT_W  current credit
state  out  2  IDLE=0, COLLECT=1, VEND=2, CHANGE=3

Behaviour:
- All outputs are registered. Each response appears on the clock edge after the input cycle that caused it.
- Reset (asynchronous, active-high) clears:
  - state to IDLE;
  - credit, change_amt and vend_item to 0;
  - vend, coin_reject, sel_short and change_valid to 0;
  - the timeout counter to 0.
  Reset in any state discards credit without a refund. It takes effect immediately and releases on the next clock.
- Coin acceptance applies only in IDLE and COLLECT:
  - The coin must be legal and credit+coin_value must not exceed MAX_CREDIT.
  - On acceptance, credit += coin_value and state becomes COLLECT.
  - Otherwise coin_reject pulses and credit is unchanged.
  - A coin presented in VEND or CHANGE is always rejected.
- Priority within one cycle in COLLECT is cancel > sel_valid > coin_valid. A coin that loses to cancel or sel_valid is rejected (coin_reject=1).
- cancel:
  - In COLLECT: change_amt=credit and the machine enters CHANGE.
  - In IDLE: ignored.
- sel_valid in COLLECT:
  - If credit >= PRICES[sel]: vend_item=sel, change_amt=credit-PRICES[sel], next state VEND.
  - Otherwise: sel_short pulses and the machine stays in COLLECT.
  - sel_valid in IDLE produces a sel_short pulse.
- VEND lasts exactly one cycle, with vend=1.
  - If change_amt != 0: next state is CHANGE.
  - Otherwise: credit is cleared and the next state is IDLE.
- CHANGE:
  - change_valid=1, with change_amt held stable until change_ack is sampled high.
  - On ack: change_valid=0, credit=0, change_amt=0, next state IDLE.
  - change_ack outside CHANGE is ignored.
  - The handshake waits indefinitely for ack; no timeout applies.
- Timeout:
  - The counter runs only in COLLECT.
  - It increments on each cycle with no coin_valid, sel_valid or cancel.
  - It clears on any such strobe, including rejected coins and short selections.
  - When the counter reaches TIMEOUT: change_amt=credit and the machine enters CHANGE (full refund). The counter clears.
- Credit never exceeds MAX_CREDIT, so no wrap-around is possible. Subtractions are unsigned and guarded by the >= compare.
- credit reflects the accepted total through VEND and CHANGE, and is cleared on leaving them.

Test Plan:
- Reset mid-CHANGE (change_valid=1) → all outputs are 0 immediately and state=0; the first post-reset coin of 5 gives credit=5.
- Coins 10, 10, 25, then sel=0 (price 15) → credit=45; vend pulses 1 cycle with vend_item=0; change_valid=1 with change_amt=30 held across 3 cycles without ack; ack → IDLE with credit=0.
- Coin 25, then sel=3 (price 40) → sel_short pulse, credit stays 25. Then coin 25 and sel=3 → credit 50; vend with vend_item=3; change_amt=10.
- Credit 90 plus coin 25 → coin_reject, credit stays 90. Coin value 7 → coin_reject. In the same cycle, coin 5 and cancel → coin_reject plus refund change_amt=90.
- Coin 10 then 10 idle cycles → on the 10th idle cycle the machine enters CHANGE with change_amt=10. A coin arriving at idle cycle 9 instead restarts the count.
- Coin 15 worth of credit, then sel=0 → exact price: vend pulse, change_amt=0, CHANGE is never entered, IDLE follows VEND.
